// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - button conditioner signal bundle
// Purpose: groups the raw button pins and the conditioned level/pulse outputs.
// Ports (interface signals):
//   btn_raw     [NUM_BTN]  raw asynchronous button pins, active-high (master drives)
//   btn_level   [NUM_BTN]  debounced stable level (slave drives)
//   btn_press   [NUM_BTN]  1-cycle pulse on debounced rise / repeat (slave drives)
//   btn_release [NUM_BTN]  1-cycle pulse on debounced fall (slave drives)
interface btn_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button synchronizer, debouncer and press/release pulser
// Purpose: per channel, 2-FF synchronizer, debounce filter, stable level and
//   one-cycle press/release pulses. Optional auto-repeat on held buttons is
//   compiled in only when the macro BTN_AUTOREPEAT_EN is defined.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    btn_conditioner_if.slave: btn_raw in, btn_level/btn_press/btn_release out
module btn_conditioner #(
  parameter int                 NUM_BTN      = 4,
  parameter int                 DEBOUNCE_BIT = 16,
  parameter int                 DEBOUNCE_VAL = 20000,
  parameter int                 REPEAT_BIT   = 24,
  parameter int                 REPEAT_DELAY = 5_000_000,
  parameter int                 REPEAT_RATE  = 2_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK  = 4'b1100
) (
  input  logic               clk,
  input  logic               rst_n,
  btn_conditioner_if.slave   bus
);

  // Reject configurations whose terminal counts cannot be represented.
  if (DEBOUNCE_VAL < 1 || DEBOUNCE_VAL >= 2**DEBOUNCE_BIT ||
      (REPEAT_MASK != '0 && (REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
                             REPEAT_DELAY >= 2**REPEAT_BIT ||
                             REPEAT_RATE >= 2**REPEAT_BIT))) begin : g_bad_cfg
    $error("btn_conditioner: counter parameters out of range");
  end

  localparam logic [DEBOUNCE_BIT-1:0] DB_LAST = DEBOUNCE_BIT'(DEBOUNCE_VAL - 1);

  logic [NUM_BTN-1:0]      sync1_q, sync2_q;
  logic [NUM_BTN-1:0]      level_q, level_d;
  logic [NUM_BTN-1:0]      press_q, press_d;
  logic [NUM_BTN-1:0]      release_q, release_d;
  logic [DEBOUNCE_BIT-1:0] cnt_q [NUM_BTN];
  logic [DEBOUNCE_BIT-1:0] cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0]      rise, fall, rpt;

  // Debounce: the level only flips after DEBOUNCE_VAL consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          rise[i]    = sync2_q[i];
          fall[i]    = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEBOUNCE_BIT'(1);
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [REPEAT_BIT-1:0] RD_LAST = REPEAT_BIT'(REPEAT_DELAY - 1);
  localparam logic [REPEAT_BIT-1:0] RR_LAST = REPEAT_BIT'(REPEAT_RATE - 1);

  logic [REPEAT_BIT-1:0] rc_q [NUM_BTN];
  logic [REPEAT_BIT-1:0] rc_d [NUM_BTN];
  logic [NUM_BTN-1:0]    ph_q, ph_d;

  // Counter and phase rest at zero unless the channel is enabled and held.
  // The release cycle (fall) is excluded so a repeat never coincides with it;
  // the press cycle is excluded naturally because level_q is still 0 there.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      rc_d[i] = '0;
      ph_d[i] = 1'b0;
      rpt[i]  = 1'b0;
      if (REPEAT_MASK[i] && level_q[i] && !fall[i]) begin
        rc_d[i] = rc_q[i] + REPEAT_BIT'(1);
        ph_d[i] = ph_q[i];
        if (!ph_q[i] && rc_q[i] == RD_LAST) begin
          rpt[i]  = 1'b1;
          rc_d[i] = '0;
          ph_d[i] = 1'b1;
        end else if (ph_q[i] && rc_q[i] == RR_LAST) begin
          rpt[i]  = 1'b1;
          rc_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) rc_q[i] <= '0;
    end else begin
      ph_q <= ph_d;
      for (int i = 0; i < NUM_BTN; i++) rc_q[i] <= rc_d[i];
    end
  end
`else
  assign rpt = '0;
`endif

  assign press_d   = rise | rpt;
  assign release_d = fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= bus.btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed self-checking bench for btn_conditioner
module tb_btn_conditioner;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  btn_conditioner_if #(.NUM_BTN(4)) bus ();

  btn_conditioner #(
    .NUM_BTN      (4),
    .DEBOUNCE_BIT (16),
    .DEBOUNCE_VAL (4),
    .REPEAT_BIT   (24),
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (3),
    .REPEAT_MASK  (4'b1100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int step, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, step, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int step,
                         input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
    chk({tag, ".level"},   step, bus.btn_level,   lvl);
    chk({tag, ".press"},   step, bus.btn_press,   prs);
    chk({tag, ".release"}, step, bus.btn_release, rel);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.btn_raw = 4'b0000;
    repeat (3) tick();
    chk_all("reset", 0, 4'b0000, 4'b0000, 4'b0000);

    // Reset asserted mid-count, then raw held through reset release.
    rst_n       = 1'b1;
    bus.btn_raw = 4'b0001;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 0, 4'b0000, 4'b0000, 4'b0000);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk_all("clean_press", e, (e >= 6) ? 4'b0001 : 4'b0000,
              (e == 6) ? 4'b0001 : 4'b0000, 4'b0000);
    end

    // Asynchronous reset clears a high level without waiting for a clock.
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 0, 4'b0000, 4'b0000, 4'b0000);
    bus.btn_raw = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk_all("post_rst_idle", 0, 4'b0000, 4'b0000, 4'b0000);

    // Release: level high, then drop.
    bus.btn_raw = 4'b0001;
    repeat (8) tick();
    chk("release_setup.level", 0, bus.btn_level, 4'b0001);
    bus.btn_raw = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk_all("release", e, (e >= 6) ? 4'b0000 : 4'b0001, 4'b0000,
              (e == 6) ? 4'b0001 : 4'b0000);
    end

    // Glitch: three high samples are one short of a flip.
    bus.btn_raw = 4'b0010;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk_all("glitch", e, 4'b0000, 4'b0000, 4'b0000);
      if (e == 3) bus.btn_raw = 4'b0000;
    end

    // Bounce 1,0,1 then hold: the stable run starts before edge 3, flip at edge 8.
    bus.btn_raw = 4'b0100;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk_all("bounce", e, (e >= 8) ? 4'b0100 : 4'b0000,
              (e == 8) ? 4'b0100 : 4'b0000, 4'b0000);
      if (e == 1) bus.btn_raw = 4'b0000;
      if (e == 2) bus.btn_raw = 4'b0100;
    end

    // Simultaneous activity: ch0/ch1 rise while ch2 falls.
    bus.btn_raw = 4'b0011;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk_all("simul", e, (e >= 6) ? 4'b0011 : 4'b0100,
              (e == 6) ? 4'b0011 : 4'b0000, (e == 6) ? 4'b0100 : 4'b0000);
    end

    // Repeat: ch3 pressed, ch0 held, ch1 released at the same edge.
    bus.btn_raw = 4'b1001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk_all("rpt_press", e, (e >= 6) ? 4'b1001 : 4'b0011,
              (e == 6) ? 4'b1000 : 4'b0000, (e == 6) ? 4'b0010 : 4'b0000);
    end
    for (int o = 1; o <= 31; o++) begin
      tick();
      chk_all("rpt_hold", o, 4'b1001,
              (AR && o >= 10 && (o - 10) % 3 == 0) ? 4'b1000 : 4'b0000, 4'b0000);
    end
    // Drop lands the release on offset 37, which is also a repeat slot.
    bus.btn_raw = 4'b0000;
    for (int o = 32; o <= 37; o++) begin
      tick();
      chk_all("rpt_release", o, (o >= 37) ? 4'b0000 : 4'b1001,
              (AR && o < 37 && (o - 10) % 3 == 0) ? 4'b1000 : 4'b0000,
              (o == 37) ? 4'b1001 : 4'b0000);
    end
    repeat (4) tick();
    chk_all("final_idle", 0, 4'b0000, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
